// File: rtl/midi_voice_pkg.sv
// midi_voice_pkg: shared event encodings, state enums and counter widths for the voice allocator
package midi_voice_pkg;
    localparam logic [1:0] EV_NONE    = 2'b00;
    localparam logic [1:0] EV_ON      = 2'b01;
    localparam logic [1:0] EV_OFF     = 2'b10;
    localparam logic [1:0] EV_ALL_OFF = 2'b11;
    localparam int AGE_W   = 8;
    localparam int STEAL_W = 16;
    typedef enum logic [1:0] {V_IDLE, V_HELD, V_REL} vstate_t;
    typedef enum logic {S_WAIT, S_COMMIT} fsm_t;
endpackage

// File: rtl/voice_pick.sv
// voice_pick: chooses the voice a note-on lands on (retrigger, idle, oldest releasing, oldest held)
module voice_pick
    import midi_voice_pkg::*;
#(
    parameter int N_VOICE = 4,
    parameter int IW      = 2
) (
    input  vstate_t [N_VOICE-1:0]            st,
    input  logic    [N_VOICE-1:0][6:0]       note,
    input  logic    [N_VOICE-1:0][AGE_W-1:0] age,
    input  logic    [6:0]                    ev_note,
    output logic    [IW-1:0]                 sel,
    output logic                             steal
);
    logic hit_a, hit_b, hit_c, hit_d;
    logic [IW-1:0] a_idx, b_idx, c_idx, d_idx;
    logic [AGE_W-1:0] c_age, d_age;
    // Scanning downward with >= leaves the lowest index on every tie
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        hit_c = 1'b0;
        hit_d = 1'b0;
        a_idx = '0;
        b_idx = '0;
        c_idx = '0;
        d_idx = '0;
        c_age = '0;
        d_age = '0;
        for (int i = N_VOICE - 1; i >= 0; i--) begin
            if (st[i] != V_IDLE && note[i] == ev_note) begin
                hit_a = 1'b1;
                a_idx = IW'(i);
            end
            if (st[i] == V_IDLE) begin
                hit_b = 1'b1;
                b_idx = IW'(i);
            end
            if (st[i] == V_REL && (!hit_c || age[i] >= c_age)) begin
                hit_c = 1'b1;
                c_idx = IW'(i);
                c_age = age[i];
            end
            if (st[i] == V_HELD && (!hit_d || age[i] >= d_age)) begin
                hit_d = 1'b1;
                d_idx = IW'(i);
                d_age = age[i];
            end
        end
        sel   = hit_a ? a_idx : hit_b ? b_idx : hit_c ? c_idx : d_idx;
        steal = !hit_a && !hit_b && !hit_c && hit_d;
    end
endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: maps decoded MIDI note events onto a pool of synth voices with release timing and stealing
module midi_voice_alloc
    import midi_voice_pkg::*;
#(
    parameter int N_VOICE   = 4,
    parameter int REL_TICKS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [1:0]             ev_type,
    input  logic [6:0]             ev_note,
    input  logic [6:0]             ev_vel,
    input  logic                   tick,
    output logic [N_VOICE-1:0]     voice_gate,
    output logic [N_VOICE-1:0]     voice_active,
    output logic [N_VOICE-1:0]     voice_trig,
    output logic [7*N_VOICE-1:0]   voice_note,
    output logic [7*N_VOICE-1:0]   voice_vel,
    output logic [STEAL_W-1:0]     steal_cnt
);
    localparam int IW = N_VOICE > 1 ? $clog2(N_VOICE) : 1;
    localparam int RW = $clog2(REL_TICKS + 1);
    fsm_t fsm;
    logic [1:0] lt;
    logic [6:0] ln, lv;
    vstate_t [N_VOICE-1:0] vst;
    logic [N_VOICE-1:0][6:0] note, vel;
    logic [N_VOICE-1:0][AGE_W-1:0] age;
    logic [N_VOICE-1:0][RW-1:0] rel;
    logic [IW-1:0] sel, off_idx;
    logic steal, off_hit, do_on, do_off, do_all;
    voice_pick #(.N_VOICE(N_VOICE), .IW(IW)) u_pick (
        .st(vst),
        .note(note),
        .age(age),
        .ev_note(ln),
        .sel(sel),
        .steal(steal)
    );
    assign ev_ready   = fsm == S_WAIT;
    assign do_on      = fsm == S_COMMIT && lt == EV_ON && lv != '0;
    assign do_off     = fsm == S_COMMIT && (lt == EV_OFF || (lt == EV_ON && lv == '0));
    assign do_all     = fsm == S_COMMIT && lt == EV_ALL_OFF;
    assign voice_note = note;
    assign voice_vel  = vel;
    always_comb begin
        voice_gate   = '0;
        voice_active = '0;
        off_hit      = 1'b0;
        off_idx      = '0;
        for (int i = N_VOICE - 1; i >= 0; i--) begin
            voice_gate[i]   = vst[i] == V_HELD;
            voice_active[i] = vst[i] != V_IDLE;
            if (vst[i] == V_HELD && note[i] == ln) begin
                off_hit = 1'b1;
                off_idx = IW'(i);
            end
        end
    end
    // A voice picked by note-on wins over any release update landing in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= S_WAIT;
            lt         <= EV_NONE;
            ln         <= '0;
            lv         <= '0;
            note       <= '0;
            vel        <= '0;
            age        <= '0;
            rel        <= '0;
            voice_trig <= '0;
            steal_cnt  <= '0;
            for (int i = 0; i < N_VOICE; i++) vst[i] <= V_IDLE;
        end else begin
            fsm <= (fsm == S_WAIT && ev_valid) ? S_COMMIT : S_WAIT;
            if (ev_valid && ev_ready) begin
                lt <= ev_type;
                ln <= ev_note;
                lv <= ev_vel;
            end
            if (do_on && steal && steal_cnt != '1) steal_cnt <= steal_cnt + 1'b1;
            for (int i = 0; i < N_VOICE; i++) begin
                voice_trig[i] <= do_on && sel == IW'(i);
                if (do_on && sel == IW'(i)) begin
                    vst[i]  <= V_HELD;
                    note[i] <= ln;
                    vel[i]  <= lv;
                    age[i]  <= '0;
                end else begin
                    if (do_on && vst[i] != V_IDLE && age[i] != '1) age[i] <= age[i] + 1'b1;
                    if ((do_off && off_hit && off_idx == IW'(i)) || (do_all && vst[i] == V_HELD)) begin
                        vst[i] <= V_REL;
                        rel[i] <= RW'(REL_TICKS);
                    end else if (tick && vst[i] == V_REL) begin
                        rel[i] <= rel[i] > RW'(1) ? rel[i] - 1'b1 : '0;
                        if (rel[i] <= RW'(1)) vst[i] <= V_IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc: directed scoreboard bench for the MIDI voice allocator
module tb_midi_voice_alloc;
    import midi_voice_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ev_valid = 1'b0;
    logic ev_ready;
    logic [1:0] ev_type = 2'b00;
    logic [6:0] ev_note = '0;
    logic [6:0] ev_vel = '0;
    logic tick = 1'b0;
    logic [3:0] voice_gate, voice_active, voice_trig;
    logic [27:0] voice_note, voice_vel;
    logic [15:0] steal_cnt;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic [3:0]  trig;
        logic [3:0]  gate;
        logic [3:0]  act;
        logic [27:0] notes;
        logic [27:0] vels;
        logic [15:0] steal;
    } exp_t;
    exp_t sb[$];
    string tags[$];
    midi_voice_alloc #(.N_VOICE(4), .REL_TICKS(16)) dut (
        .clk(clk),
        .reset(reset),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_type(ev_type),
        .ev_note(ev_note),
        .ev_vel(ev_vel),
        .tick(tick),
        .voice_gate(voice_gate),
        .voice_active(voice_active),
        .voice_trig(voice_trig),
        .voice_note(voice_note),
        .voice_vel(voice_vel),
        .steal_cnt(steal_cnt)
    );
    always #5 clk = ~clk;
    function automatic logic [27:0] pk(logic [6:0] a3, logic [6:0] a2, logic [6:0] a1, logic [6:0] a0);
        return {a3, a2, a1, a0};
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(string tag, logic [3:0] trig, logic [3:0] gate, logic [3:0] act,
                        logic [27:0] notes, logic [27:0] vels, logic [15:0] steal);
        exp_t e;
        e.trig = trig;
        e.gate = gate;
        e.act = act;
        e.notes = notes;
        e.vels = vels;
        e.steal = steal;
        sb.push_back(e);
        tags.push_back(tag);
    endtask
    task automatic check_commit();
        exp_t e;
        string tg;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: observed empty queue, required a pending entry");
        end else begin
            e = sb.pop_front();
            tg = tags.pop_front();
            chk({tg, "/trig"}, 32'(voice_trig), 32'(e.trig));
            chk({tg, "/gate"}, 32'(voice_gate), 32'(e.gate));
            chk({tg, "/active"}, 32'(voice_active), 32'(e.act));
            chk({tg, "/note"}, 32'(voice_note), 32'(e.notes));
            chk({tg, "/vel"}, 32'(voice_vel), 32'(e.vels));
            chk({tg, "/steal"}, 32'(steal_cnt), 32'(e.steal));
        end
    endtask
    task automatic send(string tag, logic [1:0] t, logic [6:0] n, logic [6:0] v, logic tk,
                        logic [3:0] trig, logic [3:0] gate, logic [3:0] act,
                        logic [27:0] notes, logic [27:0] vels, logic [15:0] steal);
        push(tag, trig, gate, act, notes, vels, steal);
        ev_valid = 1'b1;
        ev_type = t;
        ev_note = n;
        ev_vel = v;
        for (int k = 0; k < 4 && !ev_ready; k++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "/ready_hi"}, 32'(ev_ready), 32'd1);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        tick = tk;
        chk({tag, "/ready_lo"}, 32'(ev_ready), 32'd0);
        @(posedge clk);
        #1;
        tick = 1'b0;
        check_commit();
    endtask
    task automatic fire(logic [1:0] t, logic [6:0] n, logic [6:0] v);
        ev_valid = 1'b1;
        ev_type = t;
        ev_note = n;
        ev_vel = v;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic ticks(int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        ev_valid = 1'b0;
        tick = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic check_idle(string tag);
        chk({tag, "/ready"}, 32'(ev_ready), 32'd1);
        chk({tag, "/gate"}, 32'(voice_gate), 32'd0);
        chk({tag, "/active"}, 32'(voice_active), 32'd0);
        chk({tag, "/trig"}, 32'(voice_trig), 32'd0);
        chk({tag, "/note"}, 32'(voice_note), 32'd0);
        chk({tag, "/vel"}, 32'(voice_vel), 32'd0);
        chk({tag, "/steal"}, 32'(steal_cnt), 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200us");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [27:0] nacc;
        logic [27:0] vacc;
        do_reset();
        check_idle("reset");
        send("on60", EV_ON, 60, 100, 0, 4'b0001, 4'b0001, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 100), 0);
        @(posedge clk);
        #1;
        chk("on60/trig_drop", 32'(voice_trig), 32'd0);
        send("on62", EV_ON, 62, 101, 0, 4'b0010, 4'b0011, 4'b0011, pk(0, 0, 62, 60), pk(0, 0, 101, 100), 0);
        send("on64", EV_ON, 64, 102, 0, 4'b0100, 4'b0111, 4'b0111, pk(0, 64, 62, 60), pk(0, 102, 101, 100), 0);
        send("on65", EV_ON, 65, 103, 0, 4'b1000, 4'b1111, 4'b1111, pk(65, 64, 62, 60), pk(103, 102, 101, 100), 0);
        send("steal67", EV_ON, 67, 104, 0, 4'b0001, 4'b1111, 4'b1111, pk(65, 64, 62, 67), pk(103, 102, 101, 104), 1);
        send("off64", EV_OFF, 64, 0, 0, 4'b0000, 4'b1011, 4'b1111, pk(65, 64, 62, 67), pk(103, 102, 101, 104), 1);
        send("off62", EV_OFF, 62, 0, 0, 4'b0000, 4'b1001, 4'b1111, pk(65, 64, 62, 67), pk(103, 102, 101, 104), 1);
        send("oldrel70", EV_ON, 70, 50, 0, 4'b0010, 4'b1011, 4'b1111, pk(65, 64, 70, 67), pk(103, 102, 50, 104), 1);
        send("off_nomatch", EV_OFF, 99, 0, 0, 4'b0000, 4'b1011, 4'b1111, pk(65, 64, 70, 67), pk(103, 102, 50, 104), 1);
        send("off_relonly", EV_OFF, 64, 0, 0, 4'b0000, 4'b1011, 4'b1111, pk(65, 64, 70, 67), pk(103, 102, 50, 104), 1);
        send("type00", EV_NONE, 67, 5, 0, 4'b0000, 4'b1011, 4'b1111, pk(65, 64, 70, 67), pk(103, 102, 50, 104), 1);
        send("retrig64", EV_ON, 64, 90, 0, 4'b0100, 4'b1111, 4'b1111, pk(65, 64, 70, 67), pk(103, 90, 50, 104), 1);
        send("steal72", EV_ON, 72, 10, 0, 4'b1000, 4'b1111, 4'b1111, pk(72, 64, 70, 67), pk(10, 90, 50, 104), 2);
        send("alloff", EV_ALL_OFF, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111, pk(72, 64, 70, 67), pk(10, 90, 50, 104), 2);
        ticks(15);
        chk("alloff/tick15", 32'(voice_active), 32'hF);
        ticks(1);
        chk("alloff/tick16", 32'(voice_active), 32'h0);
        do_reset();
        check_idle("reset2");
        send("rel/on", EV_ON, 60, 100, 0, 4'b0001, 4'b0001, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 100), 0);
        send("rel/off", EV_OFF, 60, 0, 0, 4'b0000, 4'b0000, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 100), 0);
        ticks(15);
        chk("rel/tick15", 32'(voice_active), 32'h1);
        ticks(1);
        chk("rel/tick16", 32'(voice_active), 32'h0);
        ticks(1);
        chk("rel/tick17", 32'(voice_active), 32'h0);
        send("race/on", EV_ON, 60, 30, 0, 4'b0001, 4'b0001, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 30), 0);
        send("race/off", EV_OFF, 60, 0, 0, 4'b0000, 4'b0000, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 30), 0);
        ticks(15);
        send("race/on_tick", EV_ON, 60, 40, 1, 4'b0001, 4'b0001, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 40), 0);
        send("race/off_tick", EV_OFF, 60, 0, 1, 4'b0000, 4'b0000, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 40), 0);
        ticks(15);
        chk("race/tick15", 32'(voice_active), 32'h1);
        ticks(1);
        chk("race/tick16", 32'(voice_active), 32'h0);
        do_reset();
        send("vel0/on", EV_ON, 60, 100, 0, 4'b0001, 4'b0001, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 100), 0);
        send("vel0/off", EV_ON, 60, 0, 0, 4'b0000, 4'b0000, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 100), 0);
        send("vel0/retrig", EV_ON, 60, 80, 0, 4'b0001, 4'b0001, 4'b0001, pk(0, 0, 0, 60), pk(0, 0, 0, 80), 0);
        do_reset();
        fire(EV_ON, 10, 1);
        fire(EV_ON, 11, 2);
        fire(EV_ON, 12, 3);
        for (int k = 0; k < 253; k++) fire(EV_ON, 12, 3);
        fire(EV_ON, 13, 4);
        send("sat_tie", EV_ON, 14, 5, 0, 4'b0001, 4'b1111, 4'b1111, pk(13, 12, 11, 14), pk(4, 3, 2, 5), 1);
        do_reset();
        nacc = '0;
        vacc = '0;
        ev_valid = 1'b1;
        ev_type = EV_ON;
        for (int i = 0; i < 4; i++) begin
            ev_note = 7'(40 + i);
            ev_vel = 7'(20 + i);
            nacc = nacc | (28'(40 + i) << (7 * i));
            vacc = vacc | (28'(20 + i) << (7 * i));
            push("hold", 4'(1 << i), 4'((2 << i) - 1), 4'((2 << i) - 1), nacc, vacc, 0);
            chk("hold/ready_hi", 32'(ev_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("hold/ready_lo", 32'(ev_ready), 32'd0);
            if (i == 3) ev_valid = 1'b0;
            @(posedge clk);
            #1;
            check_commit();
        end
        send("hold/steal", EV_ON, 44, 30, 0, 4'b0001, 4'b1111, 4'b1111, pk(43, 42, 41, 44), pk(23, 22, 21, 30), 1);
        ev_valid = 1'b1;
        ev_type = EV_ON;
        ev_note = 50;
        ev_vel = 60;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        chk("midrst/in_commit", 32'(ev_ready), 32'd0);
        reset = 1'b1;
        #1;
        check_idle("midrst/async");
        reset = 1'b0;
        #1;
        chk("midrst/ready_after", 32'(ev_ready), 32'd1);
        @(posedge clk);
        #1;
        check_idle("midrst/discard");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/midi_voice_alloc.md
MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 SHALL have parameter N_VOICE, default 4: number of synth voices shared among incoming notes.
REQ-002 SHALL have parameter REL_TICKS, default 16: release duration, counted in tick pulses.
REQ-003 SHALL have port clk  in  1  system clock (100 MHz).
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ev_valid  in  1  decoded MIDI event present.
REQ-006 SHALL have port ev_ready  out  1  allocator can accept an event.
REQ-007 SHALL have port ev_type  in  2  event type: 01 note-on, 10 note-off, 11 all-notes-off, 00 ignored.
REQ-008 SHALL have port ev_note  in  7  MIDI note number.
REQ-009 SHALL have port ev_vel  in  7  MIDI velocity.
REQ-010 SHALL have port tick  in  1  one-cycle release-timebase pulse.
REQ-011 SHALL have port voice_gate  out  N_VOICE  voice held (key down).
REQ-012 SHALL have port voice_active  out  N_VOICE  voice held or releasing.
REQ-013 SHALL have port voice_trig  out  N_VOICE  one-cycle pulse on (re)allocation.
REQ-014 SHALL have port voice_note  out  7*N_VOICE  packed note per voice; voice i occupies bits [7i+6:7i].
REQ-015 SHALL have port voice_vel  out  7*N_VOICE  packed velocity per voice, same packing as voice_note.
REQ-016 SHALL have port steal_cnt  out  16  count of held-voice steals, saturating.

Function
REQ-017 Control FSM SHALL have states S_WAIT and S_COMMIT; ev_ready=1 only in S_WAIT.
- Event accepted when ev_valid && ev_ready.
- Accept latches type, note and velocity, then moves to S_COMMIT.
- S_COMMIT applies the update and returns to S_WAIT.
- Throughput is one event per 2 cycles.
REQ-018 Each voice SHALL be in state V_IDLE, V_HELD or V_REL.
- voice_gate = (V_HELD).
- voice_active = (V_HELD or V_REL).
REQ-019 A note-on with ev_vel=0 SHALL be treated as a note-off.
REQ-020 Note-on SHALL select one voice, by first matching rule below:
- (a) a non-idle voice with the same note (retrigger);
- (b) the lowest-index V_IDLE voice;
- (c) the oldest V_REL voice;
- (d) the oldest V_HELD voice (steal; steal_cnt increments).
REQ-021 Ties in age SHALL resolve to the lowest index.
REQ-022 The selected voice SHALL in S_COMMIT:
- enter V_HELD;
- load note and velocity;
- clear its age to 0;
- pulse voice_trig for exactly that cycle.
REQ-023 Each non-selected, non-idle voice SHALL increment an 8-bit age counter on every committed note-on, saturating at 255.
REQ-024 Note-off SHALL move the lowest-index V_HELD voice with a matching note to V_REL, with release counter = REL_TICKS.
- Unmatched note-off, or a match only in V_REL, SHALL have no effect.
REQ-025 All-notes-off SHALL move every V_HELD voice to V_REL, loading REL_TICKS.
- ev_type 00 SHALL commit with no effect.
REQ-026 On tick, every V_REL voice SHALL decrement its release counter; a voice reaching 0 enters V_IDLE.
- A voice entering V_REL in the same cycle as tick SHALL load REL_TICKS without decrementing.
REQ-027 A voice selected by note-on in the same cycle that tick expires it SHALL end in V_HELD.
REQ-028 steal_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-029 Reset SHALL asynchronously force:
- FSM to S_WAIT;
- all voices to V_IDLE;
- note, velocity, age and release counters to 0;
- voice_trig=0;
- steal_cnt=0.
REQ-030 Reset asserted mid-event SHALL discard the latched event; ev_ready=1 on the first cycle after reset deasserts.

Structure
REQ-031 Package midi_voice_pkg SHALL hold:
- the ev_type encodings;
- the voice-state enum;
- the FSM-state enum;
- the age width (8) and steal-counter width (16).
REQ-032 Selection logic (rules a-d, oldest-pick) SHALL be a combinational sub-module voice_pick; state and counters stay in midi_voice_alloc.

Verification
REQ-033 Reset, then note-on 60/100:
- voice 0 gate=1, note=60, vel=100;
- voice_trig=0001 for one cycle, two cycles after accept.
REQ-034 Note-on 60, 62, 64, 65, then 67 (N_VOICE=4):
- voice 0 stolen, note becomes 67;
- steal_cnt=1.
REQ-035 Note-on 60, then note-off 60, then 17 ticks:
- voice 0 in V_REL for 16 ticks;
- voice_active=0 after the 16th tick.
REQ-036 Note-on 60, then note-on 60 vel 0:
- voice 0 enters V_REL, gate=0, active=1.
- Then note-on 60 vel 80: retriggers voice 0, trig pulses, vel=80.
REQ-037 Hold ev_valid continuously over 4 note-ons:
- ev_ready alternates 1/0;
- no event lost;
- assert reset during S_COMMIT: all outputs 0, steal_cnt=0.
